// File: rtl/booth_mult_r4.sv
// Sequential radix-4 Booth multiplier with a start/busy/done handshake.
// Retires two multiplier bits per cycle and supports signed or unsigned operands per operation.
module booth_mult_r4 #(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           sgn,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] produs
);

  localparam int unsigned N  = W / 2 + 1;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned EW = W + 2;
  // Two guard bits above W+2 keep A +/- 2M from overflowing in either mode.
  localparam int unsigned AW = W + 4;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   a_q, a_d;
  logic [EW-1:0]   q_q, q_d;
  logic            q1_q, q1_d;
  logic [EW-1:0]   m_q, m_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2*W-1:0]  produs_q, produs_d;

  logic [EW-1:0]   x_ext;
  logic [EW-1:0]   y_ext;
  logic [AW-1:0]   m_ext;
  logic [AW-1:0]   addend;
  logic [AW-1:0]   sum;
  logic [AW-1:0]   a_sh;
  logic [EW-1:0]   q_sh;

  // Unsigned operands are zero-extended so the Booth recoding sees them as positive.
  assign x_ext = {{2{sgn & x[W-1]}}, x};
  assign y_ext = {{2{sgn & y[W-1]}}, y};
  assign m_ext = {{(AW - EW){m_q[EW-1]}}, m_q};

  always_comb begin
    addend = '0;
    unique case ({q_q[1:0], q1_q})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_ext << 1;
      3'b100:         addend = ~(m_ext << 1) + AW'(1);
      3'b101, 3'b110: addend = ~m_ext + AW'(1);
      default:        addend = '0;
    endcase
  end

  assign sum  = a_q + addend;
  assign a_sh = {{2{sum[AW-1]}}, sum[AW-1:2]};
  assign q_sh = {sum[1:0], q_q[EW-1:2]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    q_d      = q_q;
    q1_d     = q1_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    produs_d = produs_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = '0;
          q_d     = x_ext;
          q1_d    = 1'b0;
          m_d     = y_ext;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = a_sh;
        q_d   = q_sh;
        q1_d  = q_q[1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          // After the final shift the product occupies the low 2W bits of {A, Q}.
          produs_d = {a_sh[W-3:0], q_sh};
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      m_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      produs_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      q_q      <= q_d;
      q1_q     <= q1_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      produs_q <= produs_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign produs = produs_q;

endmodule

// File: tb/tb_booth_mult_r4.sv
// Bench for booth_mult_r4: directed W=8 cases, random W=16 and exhaustive W=4 against a
// reference product model, with expected results queued at issue and popped at done.
module tb_booth_mult_r4;

  logic        clk;
  logic        rst_n;
  logic        start_tb;
  logic        sgn_tb;
  logic [31:0] x_tb;
  logic [31:0] y_tb;
  logic [1:0]  sel;

  logic        busy8, done8, busy16, done16, busy4, done4;
  logic [15:0] p8;
  logic [31:0] p16;
  logic [7:0]  p4;

  logic        cur_busy;
  logic        cur_done;
  logic [63:0] cur_produs;

  logic [63:0] sb[$];
  int          checks;
  int          errors;

  booth_mult_r4 #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_tb && (sel == 2'd0)), .sgn(sgn_tb),
    .x(x_tb[7:0]), .y(y_tb[7:0]), .busy(busy8), .done(done8), .produs(p8)
  );

  booth_mult_r4 #(.W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_tb && (sel == 2'd1)), .sgn(sgn_tb),
    .x(x_tb[15:0]), .y(y_tb[15:0]), .busy(busy16), .done(done16), .produs(p16)
  );

  booth_mult_r4 #(.W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_tb && (sel == 2'd2)), .sgn(sgn_tb),
    .x(x_tb[3:0]), .y(y_tb[3:0]), .busy(busy4), .done(done4), .produs(p4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    cur_busy   = busy8;
    cur_done   = done8;
    cur_produs = {48'd0, p8};
    case (sel)
      2'd1: begin
        cur_busy   = busy16;
        cur_done   = done16;
        cur_produs = {32'd0, p16};
      end
      2'd2: begin
        cur_busy   = busy4;
        cur_done   = done4;
        cur_produs = {56'd0, p4};
      end
      default: ;
    endcase
  end

  function automatic logic [63:0] ref_mul(input int w, input bit s, input logic [31:0] a,
                                          input logic [31:0] b);
    longint mask;
    longint av;
    longint bv;
    longint p;
    mask = (longint'(1) << w) - 1;
    av   = longint'(a) & mask;
    bv   = longint'(b) & mask;
    if (s && a[w-1]) av = av - (longint'(1) << w);
    if (s && b[w-1]) bv = bv - (longint'(1) << w);
    p = av * bv;
    return 64'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the operation is accepted on the next rising edge.
  task automatic issue_op(input int w, input bit s, input logic [31:0] a, input logic [31:0] b);
    sgn_tb   = s;
    x_tb     = a;
    y_tb     = b;
    start_tb = 1'b1;
    sb.push_back(ref_mul(w, s, a, b));
    @(negedge clk);
    start_tb = 1'b0;
  endtask

  // lat0 = edges already elapsed since accept; returns at the falling edge where done is seen.
  task automatic finish_op(input int w, input int lat0);
    int          lat;
    int          busy_cnt;
    bit          seen;
    bit          stable;
    logic [63:0] old;
    logic [63:0] exp;
    lat      = lat0;
    busy_cnt = 0;
    seen     = 1'b0;
    stable   = 1'b1;
    old      = cur_produs;
    while (!seen && lat < 100) begin
      if (cur_done) begin
        seen = 1'b1;
      end else begin
        if (cur_busy) busy_cnt++;
        if (cur_produs !== old) stable = 1'b0;
        @(negedge clk);
        lat++;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    exp = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD;
    if (seen) begin
      check("produs", cur_produs, exp);
      check("latency", 64'(lat), 64'(w / 2 + 2));
      check("busy_cycles", 64'(busy_cnt), 64'(w / 2 + 2 - lat0));
      check("busy_low_at_done", 64'(cur_busy), 64'd0);
      check("produs_held", 64'(stable), 64'd1);
    end
  endtask

  initial begin
    bit any_done;
    checks   = 0;
    errors   = 0;
    sel      = 2'd0;
    rst_n    = 1'b0;
    start_tb = 1'b0;
    sgn_tb   = 1'b0;
    x_tb     = '0;
    y_tb     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_produs8", 64'(p8), 64'd0);
    check("rst_busy16", 64'(busy16), 64'd0);
    check("rst_produs4", 64'(p4), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue_op(8, 1'b1, 32'h80, 32'h80);
    finish_op(8, 1);
    check("s80x80", cur_produs, 64'h4000);
    @(negedge clk);
    check("done_one_cycle", 64'(cur_done), 64'd0);

    issue_op(8, 1'b0, 32'hFF, 32'hFF);
    finish_op(8, 1);
    check("uFFxFF", cur_produs, 64'hFE01);
    issue_op(8, 1'b1, 32'hFF, 32'hFF);
    finish_op(8, 1);
    check("sFFxFF", cur_produs, 64'h0001);
    issue_op(8, 1'b1, 32'h80, 32'h7F);
    finish_op(8, 1);
    check("s80x7F", cur_produs, 64'hC080);
    issue_op(8, 1'b0, 32'h80, 32'h7F);
    finish_op(8, 1);
    check("u80x7F", cur_produs, 64'h3F80);
    @(negedge clk);

    // Start and new operands while busy must be ignored.
    issue_op(8, 1'b0, 32'h12, 32'h34);
    start_tb = 1'b1;
    sgn_tb   = 1'b1;
    x_tb     = 32'hFF;
    y_tb     = 32'hFF;
    @(negedge clk);
    @(negedge clk);
    start_tb = 1'b0;
    finish_op(8, 3);
    check("busy_ignore", cur_produs, 64'h03A8);
    any_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done8) any_done = 1'b1;
    end
    check("no_extra_done", 64'(any_done), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    // Start in the done cycle is accepted; old product held until the new one lands.
    issue_op(8, 1'b0, 32'h05, 32'h07);
    finish_op(8, 1);
    issue_op(8, 1'b0, 32'h10, 32'h10);
    check("hold_old", cur_produs, 64'h0023);
    finish_op(8, 1);
    check("b2b_new", cur_produs, 64'h0100);
    @(negedge clk);

    // Asynchronous reset mid-operation.
    issue_op(8, 1'b1, 32'h7F, 32'h81);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_done", 64'(done8), 64'd0);
    check("abort_produs", 64'(p8), 64'd0);
    void'(sb.pop_front());
    @(negedge clk);
    rst_n    = 1'b1;
    any_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done8) any_done = 1'b1;
    end
    check("abort_no_done", 64'(any_done), 64'd0);
    issue_op(8, 1'b0, 32'h03, 32'h05);
    finish_op(8, 1);
    check("after_abort", cur_produs, 64'h000F);
    @(negedge clk);

    sel = 2'd1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      issue_op(16, s[0], 32'h8000, 32'h8000);
      finish_op(16, 1);
      issue_op(16, s[0], 32'hFFFF, 32'h7FFF);
      finish_op(16, 1);
      for (int i = 0; i < 1500; i++) begin
        issue_op(16, s[0], $urandom & 32'hFFFF, $urandom & 32'hFFFF);
        finish_op(16, 1);
      end
    end
    @(negedge clk);

    sel = 2'd2;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          issue_op(4, s[0], 32'(a), 32'(b));
          finish_op(4, 1);
        end
      end
    end
    @(negedge clk);
    check("done4_one_cycle", 64'(cur_done), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
